// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the transmitter busy-rise timeout and the default end-of-packet byte.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  // Cycles to wait for tx_busy to rise after tx_start before moving on anyway.
  localparam int BUSY_RISE_TIMEOUT = 4;

  // Newline terminates a packet unless the instance overrides it.
  localparam logic [7:0] DEFAULT_EOP_CHAR = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request searching upward from
// (last_grant + 1) mod N with wrap-around. Purely combinational.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last_grant,
  output logic         found,
  output logic [2:0]   idx
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]   cand_idx [N];
  logic [N-1:0] hit;

  // Candidate gi is the source gi+1 positions after the last grant.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum          = {1'b0, last_grant} + 4'(gi + 1);
      assign cand_idx[gi] = 3'(sum % 4'(N));
      assign hit[gi]      = |(req & (ONE << cand_idx[gi]));
    end
  endgenerate

  // Nearest candidate wins: scan from farthest to nearest so the nearest overwrites.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte FIFOs. Round-robin grants that
// stay with a source for a burst (up to MAX_BURST bytes, or up to EOP_CHAR
// in packet mode). The arbiter alone pops FIFOs and pulses tx_start.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         N         = 4,
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] EOP_CHAR  = DEFAULT_EOP_CHAR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   src_en,
  input  logic           pkt_mode,
  input  logic [N-1:0]   fifo_empty,
  input  logic [8*N-1:0] fifo_q,
  output logic [N-1:0]   fifo_rden,
  input  logic           tx_busy,
  output logic           tx_start,
  output logic [7:0]     tx_dat,
  output logic           grant_vld,
  output logic [2:0]     grant_id
);

  localparam int         IW           = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] BURST_LIMIT  = 8'(MAX_BURST);
  localparam logic [2:0] TIMEOUT_LAST = 3'(BUSY_RISE_TIMEOUT - 1);
  localparam logic [2:0] LAST_SRC     = 3'(N - 1);

  state_t     state_reg, state_next;
  logic [2:0] grant_id_reg;
  logic [2:0] last_grant_reg;
  logic       grant_vld_reg;
  logic [7:0] burst_cnt_reg;
  logic [7:0] tx_dat_reg;
  logic [2:0] wait_cnt_reg;

  logic [N-1:0] req;
  logic         pick_found;
  logic [2:0]   pick_idx;
  logic [7:0]   q_arr [N];
  logic [7:0]   grant_q;
  logic         grant_req;
  logic         busy_timeout;
  logic         eop_sent;
  logic         keep_grant;

  assign req = src_en & ~fifo_empty;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_reg),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_q
      assign q_arr[gi] = fifo_q[8*gi +: 8];
    end
  endgenerate

  assign grant_q      = q_arr[grant_id_reg[IW-1:0]];
  assign grant_req    = req[grant_id_reg[IW-1:0]];
  assign busy_timeout = (wait_cnt_reg == TIMEOUT_LAST);
  assign eop_sent     = pkt_mode && (tx_dat_reg == EOP_CHAR);
  // Stay with the owner only while it still has enabled data, burst budget
  // remains and the byte just sent did not close a packet.
  assign keep_grant   = grant_req && (burst_cnt_reg < BURST_LIMIT) && !eop_sent;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: one pass through POP/LOAD/START/WAIT_* per byte.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (pick_found) state_next = POP;
      POP:       state_next = LOAD;
      LOAD:      state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy || busy_timeout) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = keep_grant ? POP : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Strobe outputs decoded from the current state.
  always_comb begin
    fifo_rden = '0;
    for (int i = 0; i < N; i++) begin
      fifo_rden[i] = (state_reg == POP) && (grant_id_reg == 3'(i));
    end
    tx_start = (state_reg == START);
  end

  // Grant bookkeeping, burst counting, byte capture and busy-rise timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_vld_reg  <= 1'b0;
      grant_id_reg   <= 3'd0;
      last_grant_reg <= LAST_SRC;
      burst_cnt_reg  <= 8'd0;
      tx_dat_reg     <= 8'h00;
      wait_cnt_reg   <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_id_reg  <= pick_idx;
            grant_vld_reg <= 1'b1;
            burst_cnt_reg <= 8'd0;
          end
        end
        LOAD: tx_dat_reg <= grant_q;
        START: begin
          if (burst_cnt_reg < BURST_LIMIT) burst_cnt_reg <= burst_cnt_reg + 8'd1;
          wait_cnt_reg <= 3'd0;
        end
        WAIT_BUSY: begin
          if (!busy_timeout) wait_cnt_reg <= wait_cnt_reg + 3'd1;
        end
        WAIT_DONE: begin
          if (!tx_busy && !keep_grant) begin
            last_grant_reg <= grant_id_reg;
            grant_vld_reg  <= 1'b0;
            burst_cnt_reg  <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_dat    = tx_dat_reg;
  assign grant_vld = grant_vld_reg;
  assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Two instances share the control
// inputs: instance 0 uses MAX_BURST=16, instance 1 uses MAX_BURST=1.
// Each has its own registered-read FIFO models and a 10-cycle transmitter.
module tb_uart_tx_arbiter;

  localparam int NS    = 4;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [NS-1:0] src_en = '0;
  logic          pkt_mode = 1'b0;
  logic          flush = 1'b0;

  logic [NS-1:0]   fifo_empty [2];
  logic [8*NS-1:0] fifo_q [2];
  logic [NS-1:0]   fifo_rden [2];
  logic            tx_busy [2];
  logic            tx_start [2];
  logic [7:0]      tx_dat [2];
  logic            grant_vld [2];
  logic [2:0]      grant_id [2];

  logic [7:0] mem [2][NS][DEPTH];
  int         wr_ptr [2][NS];
  int         rd_ptr [2][NS] = '{default: 0};
  int         rden_cnt [2][NS] = '{default: 0};
  int         busy_cnt [2] = '{0, 0};
  int         tx_cnt [2] = '{0, 0};
  logic       bad_rden [2] = '{1'b0, 1'b0};
  logic [7:0] log_dat [2][64];
  logic [2:0] log_gid [2][64];
  int         log_cyc [2][64];
  int         cyc = 0;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      uart_tx_arbiter #(
        .N(NS), .MAX_BURST(gi == 0 ? 16 : 1), .EOP_CHAR(8'h0A)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .src_en     (src_en),
        .pkt_mode   (pkt_mode),
        .fifo_empty (fifo_empty[gi]),
        .fifo_q     (fifo_q[gi]),
        .fifo_rden  (fifo_rden[gi]),
        .tx_busy    (tx_busy[gi]),
        .tx_start   (tx_start[gi]),
        .tx_dat     (tx_dat[gi]),
        .grant_vld  (grant_vld[gi]),
        .grant_id   (grant_id[gi])
      );

      for (gj = 0; gj < NS; gj++) begin : g_empty
        assign fifo_empty[gi][gj] = (wr_ptr[gi][gj] == rd_ptr[gi][gj]);
      end

      assign tx_busy[gi] = (busy_cnt[gi] != 0);

      // FIFO models, transmitter model and transmit log for this instance.
      always @(posedge clk) begin
        if (flush) begin
          tx_cnt[gi] <= 0;
          for (int s = 0; s < NS; s++) begin
            rd_ptr[gi][s]   <= wr_ptr[gi][s];
            rden_cnt[gi][s] <= 0;
          end
        end else begin
          for (int s = 0; s < NS; s++) begin
            if (fifo_rden[gi][s]) begin
              rden_cnt[gi][s] <= rden_cnt[gi][s] + 1;
              if (fifo_empty[gi][s]) bad_rden[gi] <= 1'b1;
              else begin
                fifo_q[gi][8*s +: 8] <= mem[gi][s][rd_ptr[gi][s] % DEPTH];
                rd_ptr[gi][s] <= rd_ptr[gi][s] + 1;
              end
            end
          end
          if ($countones(fifo_rden[gi]) > 1) bad_rden[gi] <= 1'b1;
          if (tx_start[gi]) begin
            log_dat[gi][tx_cnt[gi] % 64] <= tx_dat[gi];
            log_gid[gi][tx_cnt[gi] % 64] <= grant_id[gi];
            log_cyc[gi][tx_cnt[gi] % 64] <= cyc;
            tx_cnt[gi] <= tx_cnt[gi] + 1;
          end
        end
        if (tx_start[gi])        busy_cnt[gi] <= 10;
        else if (busy_cnt[gi] > 0) busy_cnt[gi] <= busy_cnt[gi] - 1;
      end
    end
  endgenerate

  // Expected transmit sequences.
  logic [7:0] pk_dat [6] = '{8'h41, 8'h42, 8'h0A, 8'h58, 8'h43, 8'h44};
  logic [2:0] pk_gid [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
  logic [7:0] en_dat [3] = '{8'h20, 8'h21, 8'hEE};
  logic [2:0] en_gid [3] = '{3'd0, 3'd0, 3'd1};

  task automatic push(input int inst, input int src, input logic [7:0] b);
    mem[inst][src][wr_ptr[inst][src] % DEPTH] = b;
    wr_ptr[inst][src] = wr_ptr[inst][src] + 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; src_en = '0; pkt_mode = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (tx_cnt[inst] >= n && !grant_vld[inst] && !tx_busy[inst]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; src_en = '0; pkt_mode = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wr_ptr[0][i] = 0;
      wr_ptr[1][i] = 0;
    end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fifo_rden[d] !== 4'b0000 || tx_start[d] !== 1'b0 || tx_dat[d] !== 8'h00 ||
          grant_vld[d] !== 1'b0 || grant_id[d] !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got rden=%b start=%b dat=%h vld=%b id=%0d want all zero",
                 d, fifo_rden[d], tx_start[d], tx_dat[d], grant_vld[d], grant_id[d]);
      end
    end
    $display("reset: outputs idle on both instances");
  endtask

  task automatic test_single();
    bit ok;
    push(0, 0, 8'h55);
    push(0, 0, 8'hAA);
    src_en = 4'b0001;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_rden[0] !== 4'b0001) begin
      errors++; $display("FAIL single_pop got %b want 0001", fifo_rden[0]);
    end
    @(negedge clk);
    checks++;
    if (fifo_rden[0] !== 4'b0000) begin
      errors++; $display("FAIL single_pop_width got %b want 0000", fifo_rden[0]);
    end
    @(negedge clk);
    checks++;
    if (tx_start[0] !== 1'b1 || tx_dat[0] !== 8'h55 || grant_vld[0] !== 1'b1 || grant_id[0] !== 3'd0) begin
      errors++;
      $display("FAIL single_first_start got start=%b dat=%h vld=%b id=%0d want 1 55 1 0",
               tx_start[0], tx_dat[0], grant_vld[0], grant_id[0]);
    end
    wait_done(0, 2, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got tx_cnt=%0d want 2 then idle", tx_cnt[0]); end
    checks++;
    if (tx_cnt[0] !== 2 || log_dat[0][0] !== 8'h55 || log_dat[0][1] !== 8'hAA) begin
      errors++;
      $display("FAIL single_bytes got cnt=%0d %h %h want 2 55 aa", tx_cnt[0], log_dat[0][0], log_dat[0][1]);
    end
    checks++;
    if (rden_cnt[0][0] !== 2) begin errors++; $display("FAIL single_rden_count got %0d want 2", rden_cnt[0][0]); end
    checks++;
    if (log_cyc[0][1] - log_cyc[0][0] !== 14) begin
      errors++; $display("FAIL single_b2b_gap got %0d want 14", log_cyc[0][1] - log_cyc[0][0]);
    end
    checks++;
    if (tx_cnt[1] !== 0) begin errors++; $display("FAIL single_other_inst got %0d want 0", tx_cnt[1]); end
    $display("single: sent %h %h rden=%0d", log_dat[0][0], log_dat[0][1], rden_cnt[0][0]);
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    src_en = 4'b0111;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 3; k++) push(1, s, 8'(16 * s + k));
    wait_done(1, 9, 600, ok);
    checks++;
    if (!ok || tx_cnt[1] !== 9) begin
      errors++; $display("FAIL rr_count got %0d want 9 (done=%0d)", tx_cnt[1], ok);
    end
    for (int j = 0; j < 9; j++) begin
      checks++;
      if (log_gid[1][j] !== 3'(j % 3) || log_dat[1][j] !== 8'(16 * (j % 3) + j / 3)) begin
        errors++;
        $display("FAIL rr_byte%0d got id=%0d dat=%h want id=%0d dat=%h", j, log_gid[1][j], log_dat[1][j],
                 j % 3, 8'(16 * (j % 3) + j / 3));
      end
    end
    $display("round_robin: %0d bytes, MAX_BURST=1", tx_cnt[1]);
  endtask

  task automatic test_pkt_mode();
    bit ok;
    apply_reset();
    pkt_mode = 1'b1;
    src_en = 4'b0011;
    push(0, 0, 8'h41); push(0, 0, 8'h42); push(0, 0, 8'h0A); push(0, 0, 8'h43); push(0, 0, 8'h44);
    push(0, 1, 8'h58);
    wait_done(0, 6, 600, ok);
    checks++;
    if (!ok || tx_cnt[0] !== 6) begin errors++; $display("FAIL pkt_count got %0d want 6", tx_cnt[0]); end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (log_gid[0][j] !== pk_gid[j] || log_dat[0][j] !== pk_dat[j]) begin
        errors++;
        $display("FAIL pkt_byte%0d got id=%0d dat=%h want id=%0d dat=%h", j, log_gid[0][j], log_dat[0][j],
                 pk_gid[j], pk_dat[j]);
      end
    end
    checks++;
    if (log_cyc[0][3] - log_cyc[0][2] !== 15) begin
      errors++; $display("FAIL pkt_rotate_gap got %0d want 15", log_cyc[0][3] - log_cyc[0][2]);
    end
    pkt_mode = 1'b0;
    $display("pkt_mode: %0d bytes, grant moved after EOP", tx_cnt[0]);
  endtask

  task automatic test_max_burst();
    bit ok;
    logic [7:0] exp_d;
    logic [2:0] exp_g;
    apply_reset();
    src_en = 4'b0011;
    for (int k = 0; k < 20; k++) push(0, 0, 8'(8'h80 + k));
    push(0, 1, 8'hC1);
    wait_done(0, 21, 1500, ok);
    checks++;
    if (!ok || tx_cnt[0] !== 21) begin errors++; $display("FAIL burst_count got %0d want 21", tx_cnt[0]); end
    for (int j = 0; j < 21; j++) begin
      if (j < 16)       begin exp_g = 3'd0; exp_d = 8'(8'h80 + j); end
      else if (j == 16) begin exp_g = 3'd1; exp_d = 8'hC1; end
      else              begin exp_g = 3'd0; exp_d = 8'(8'h80 + j - 1); end
      checks++;
      if (log_gid[0][j] !== exp_g || log_dat[0][j] !== exp_d) begin
        errors++;
        $display("FAIL burst_byte%0d got id=%0d dat=%h want id=%0d dat=%h", j, log_gid[0][j], log_dat[0][j],
                 exp_g, exp_d);
      end
    end
    $display("max_burst: %0d bytes, rotation after 16", tx_cnt[0]);
  endtask

  task automatic test_src_en_drop();
    bit ok;
    apply_reset();
    src_en = 4'b0011;
    for (int k = 0; k < 5; k++) push(0, 0, 8'(8'h20 + k));
    push(0, 1, 8'hEE);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_cnt[0] >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL en_second_start got tx_cnt=%0d want 2", tx_cnt[0]); end
    src_en = 4'b0010;
    wait_done(0, 3, 400, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (tx_cnt[0] !== 3) begin errors++; $display("FAIL en_count got %0d want 3", tx_cnt[0]); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (log_gid[0][j] !== en_gid[j] || log_dat[0][j] !== en_dat[j]) begin
        errors++;
        $display("FAIL en_byte%0d got id=%0d dat=%h want id=%0d dat=%h", j, log_gid[0][j], log_dat[0][j],
                 en_gid[j], en_dat[j]);
      end
    end
    checks++;
    if (wr_ptr[0][0] - rd_ptr[0][0] !== 3 || rden_cnt[0][0] !== 2) begin
      errors++;
      $display("FAIL en_src0_left got left=%0d rden=%0d want 3 2", wr_ptr[0][0] - rd_ptr[0][0], rden_cnt[0][0]);
    end
    $display("src_en_drop: %0d bytes, src0 keeps %0d", tx_cnt[0], wr_ptr[0][0] - rd_ptr[0][0]);
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    src_en = 4'b0011;
    push(0, 0, 8'h01);
    wait_done(0, 1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_first_grant got tx_cnt=%0d want 1", tx_cnt[0]); end
    push(0, 0, 8'h02); push(0, 1, 8'h31); push(0, 1, 8'h32);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_start[0] === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || grant_id[0] !== 3'd1 || tx_dat[0] !== 8'h31) begin
      errors++; $display("FAIL mid_rotated_start got id=%0d dat=%h want 1 31", grant_id[0], tx_dat[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rden[0] !== 4'b0000 || tx_start[0] !== 1'b0 || grant_vld[0] !== 1'b0 ||
        grant_id[0] !== 3'd0 || tx_dat[0] !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs got rden=%b start=%b vld=%b id=%0d dat=%h want all zero",
               fifo_rden[0], tx_start[0], grant_vld[0], grant_id[0], tx_dat[0]);
    end
    rst = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_start[0] === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || grant_id[0] !== 3'd0 || tx_dat[0] !== 8'h02) begin
      errors++; $display("FAIL mid_restart_src0 got id=%0d dat=%h want 0 02", grant_id[0], tx_dat[0]);
    end
    wait_done(0, 4, 400, ok);
    checks++;
    if (!ok || log_dat[0][3] !== 8'h32) begin
      errors++; $display("FAIL mid_tail got cnt=%0d dat=%h want 4 32", tx_cnt[0], log_dat[0][3]);
    end
    src_en = '0;
    $display("reset_mid: outputs cleared, restart at src0");
  endtask

  task automatic test_no_empty_read();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bad_rden[d] !== 1'b0) begin
        errors++; $display("FAIL rden_sanity inst=%0d got empty/multi read=%b want 0", d, bad_rden[d]);
      end
    end
    $display("rden_sanity: checked both instances");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pkt_mode();
    test_max_burst();
    test_src_en_drop();
    test_reset_mid();
    test_no_empty_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
